pong_match_controller: RTL and testbench

//  Match sequencer for the Pong game. Sits between the ball and the score displays.

---
 rtl/pong_match_controller.sv | 158 +++++++++++++++
 tb/tb_pong_match_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
// Pong match sequencer: owns both scores, parks and releases the ball, and decides the winner.
// All timing is counted in game ticks; every output comes straight from a register.
module pong_match_controller #(
  parameter int WIN_SCORE   = 11,
  parameter int WIN_BY_TWO  = 1,
  parameter int MAX_SCORE   = 99,
  parameter int SERVE_TICKS = 64,
  parameter int PAUSE_TICKS = 128
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_pointLeft,
  input  logic       i_pointRight,
  output logic [6:0] o_leftScore,
  output logic [6:0] o_rightScore,
  output logic       o_ballHold,
  output logic       o_servePulse,
  output logic       o_serveDir,
  output logic       o_gameOver,
  output logic       o_winner,
  output logic [2:0] o_state
);

  localparam int TMAX = (SERVE_TICKS > PAUSE_TICKS) ? SERVE_TICKS : PAUSE_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_TICKS - 1);
  localparam logic [TW-1:0] PAUSE_LOAD = TW'(PAUSE_TICKS - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [6:0]    MAX_S      = 7'(MAX_SCORE);
  localparam logic [6:0]    WIN_S      = 7'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t        r_state, w_stateNext;
  logic [TW-1:0] r_timer, w_timerNext;
  logic [6:0]    r_left, w_leftNext, r_right, w_rightNext;
  logic          r_startQ, r_ballHold, r_servePulse, r_serveDir, r_gameOver, r_winner;
  logic          w_ballHoldNext, w_servePulseNext, w_serveDirNext, w_gameOverNext, w_winnerNext;
  logic          w_startEdge, w_timerDone, w_win;
  logic [6:0]    w_hi, w_lo, w_diff;

  assign w_startEdge = i_start & ~r_startQ;
  assign w_timerDone = (r_timer == '0);
  assign w_hi        = (r_right > r_left) ? r_right : r_left;
  assign w_lo        = (r_right > r_left) ? r_left : r_right;
  assign w_diff      = (w_hi > w_lo) ? (w_hi - w_lo) : 7'd0;
  assign w_win       = (w_hi >= MAX_S) ||
                       ((w_hi >= WIN_S) && ((WIN_BY_TWO == 0) || (w_diff >= 7'd2)));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_left       <= 7'd0;
      r_right      <= 7'd0;
      r_startQ     <= 1'b0;
      r_ballHold   <= 1'b1;
      r_servePulse <= 1'b0;
      r_serveDir   <= 1'b1;
      r_gameOver   <= 1'b0;
      r_winner     <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_timer      <= w_timerNext;
      r_left       <= w_leftNext;
      r_right      <= w_rightNext;
      r_startQ     <= i_start;
      r_ballHold   <= w_ballHoldNext;
      r_servePulse <= w_servePulseNext;
      r_serveDir   <= w_serveDirNext;
      r_gameOver   <= w_gameOverNext;
      r_winner     <= w_winnerNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_timerNext    = r_timer;
    w_leftNext     = r_left;
    w_rightNext    = r_right;
    w_serveDirNext = r_serveDir;
    w_gameOverNext = r_gameOver;
    w_winnerNext   = r_winner;
    case (r_state)
      IDLE: begin
        if (w_startEdge) begin
          w_stateNext = SERVE;
          w_timerNext = SERVE_LOAD;
        end
      end
      SERVE: begin
        if (i_tick) begin
          if (w_timerDone) w_stateNext = PLAY;
          else             w_timerNext = r_timer - TIMER_ONE;
        end
      end
      PLAY: begin
        // A simultaneous pair of point pulses is a let: pause without scoring.
        if (i_pointLeft || i_pointRight) begin
          w_stateNext = POINT;
          w_timerNext = PAUSE_LOAD;
          if (i_pointLeft && !i_pointRight) begin
            w_leftNext     = (r_left < MAX_S) ? r_left + 7'd1 : r_left;
            w_serveDirNext = 1'b0;
          end else if (i_pointRight && !i_pointLeft) begin
            w_rightNext    = (r_right < MAX_S) ? r_right + 7'd1 : r_right;
            w_serveDirNext = 1'b1;
          end
        end
      end
      POINT: begin
        if (w_win) begin
          w_stateNext    = OVER;
          w_gameOverNext = 1'b1;
          w_winnerNext   = (r_right > r_left);
        end else if (i_tick) begin
          if (w_timerDone) begin
            w_stateNext = SERVE;
            w_timerNext = SERVE_LOAD;
          end else begin
            w_timerNext = r_timer - TIMER_ONE;
          end
        end
      end
      OVER: begin
        if (w_startEdge) begin
          w_stateNext    = SERVE;
          w_timerNext    = SERVE_LOAD;
          w_leftNext     = 7'd0;
          w_rightNext    = 7'd0;
          w_gameOverNext = 1'b0;
          w_serveDirNext = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
    w_ballHoldNext   = (w_stateNext != PLAY);
    w_servePulseNext = (r_state == SERVE) && (w_stateNext == PLAY);
  end

  assign o_leftScore  = r_left;
  assign o_rightScore = r_right;
  assign o_ballHold   = r_ballHold;
  assign o_servePulse = r_servePulse;
  assign o_serveDir   = r_serveDir;
  assign o_gameOver   = r_gameOver;
  assign o_winner     = r_winner;
  assign o_state      = r_state;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: three instances share stimulus so that
// win-by-two, first-to-win and score-cap configurations can be checked side by side.
module tb_pong_match_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, start = 1'b0, pointL = 1'b0, pointR = 1'b0;

  logic [6:0] aLeft, aRight, bLeft, bRight, cLeft, cRight;
  logic       aHold, aPulse, aDir, aOver, aWinner;
  logic       bHold, bPulse, bDir, bOver, bWinner;
  logic       cHold, cPulse, cDir, cOver, cWinner;
  logic [2:0] aState, bState, cState;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clock = ~clock;

  pong_match_controller #(.WIN_SCORE(11), .WIN_BY_TWO(1), .MAX_SCORE(99),
                          .SERVE_TICKS(4), .PAUSE_TICKS(2)) dutA (
    .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_start(start),
    .i_pointLeft(pointL), .i_pointRight(pointR),
    .o_leftScore(aLeft), .o_rightScore(aRight), .o_ballHold(aHold),
    .o_servePulse(aPulse), .o_serveDir(aDir), .o_gameOver(aOver),
    .o_winner(aWinner), .o_state(aState));

  pong_match_controller #(.WIN_SCORE(11), .WIN_BY_TWO(0), .MAX_SCORE(99),
                          .SERVE_TICKS(4), .PAUSE_TICKS(2)) dutB (
    .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_start(start),
    .i_pointLeft(pointL), .i_pointRight(pointR),
    .o_leftScore(bLeft), .o_rightScore(bRight), .o_ballHold(bHold),
    .o_servePulse(bPulse), .o_serveDir(bDir), .o_gameOver(bOver),
    .o_winner(bWinner), .o_state(bState));

  pong_match_controller #(.WIN_SCORE(5), .WIN_BY_TWO(1), .MAX_SCORE(3),
                          .SERVE_TICKS(4), .PAUSE_TICKS(2)) dutC (
    .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_start(start),
    .i_pointLeft(pointL), .i_pointRight(pointR),
    .o_leftScore(cLeft), .o_rightScore(cRight), .o_ballHold(cHold),
    .o_servePulse(cPulse), .o_serveDir(cDir), .o_gameOver(cOver),
    .o_winner(cWinner), .o_state(cState));

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one clock cycle of inputs, then samples point sits 1ns after the edge.
  task automatic applyStimulus(input logic t, input logic s, input logic l, input logic r);
    tick = t; start = s; pointL = l; pointR = r;
    @(posedge clock);
    #1;
    tick = 1'b0; start = 1'b0; pointL = 1'b0; pointR = 1'b0;
  endtask

  task automatic serveTicks(input int spacing);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (spacing - 1) applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
    end
  endtask

  // From PLAY: score, sit out the two-tick pause, serve, and return to PLAY.
  task automatic scorePoint(input logic l, input logic r);
    applyStimulus(0, 0, l, r);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    serveTicks(1);
  endtask

  initial begin
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("resetState", aState, 0);
    checkOutput("resetLeft", aLeft, 0);
    checkOutput("resetRight", aRight, 0);
    checkOutput("resetHold", aHold, 1);
    checkOutput("resetPulse", aPulse, 0);
    checkOutput("resetDir", aDir, 1);
    checkOutput("resetOver", aOver, 0);
    checkOutput("resetWinner", aWinner, 0);

    applyStimulus(0, 1, 0, 0);
    checkOutput("startToServe", aState, 1);
    checkOutput("serveHold", aHold, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (6) applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      if (i == 2) checkOutput("serveAfter3Ticks", aState, 1);
    end
    checkOutput("serveToPlay", aState, 2);
    checkOutput("servePulseHigh", aPulse, 1);
    checkOutput("playHold", aHold, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("servePulseOneCycle", aPulse, 0);
    checkOutput("playStays", aState, 2);

    applyStimulus(0, 0, 0, 1);
    checkOutput("rightPointScore", aRight, 1);
    checkOutput("rightPointDir", aDir, 1);
    checkOutput("rightPointState", aState, 3);
    checkOutput("pointHold", aHold, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pointNoOver", aOver, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("pauseAfter1Tick", aState, 3);
    applyStimulus(1, 0, 0, 0);
    checkOutput("pauseToServe", aState, 1);

    applyStimulus(0, 0, 1, 0);
    checkOutput("ignoreLeftInServe", aLeft, 0);
    checkOutput("ignoreStateServe", aState, 1);
    serveTicks(1);
    checkOutput("serveSpacing1", aState, 2);

    applyStimulus(0, 0, 1, 1);
    checkOutput("letLeft", aLeft, 0);
    checkOutput("letRight", aRight, 1);
    checkOutput("letState", aState, 3);
    checkOutput("letDir", aDir, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    serveTicks(1);
    checkOutput("letBackToPlay", aState, 2);

    repeat (4) scorePoint(0, 1);
    repeat (3) scorePoint(1, 0);
    checkOutput("preResetLeft", aLeft, 3);
    checkOutput("preResetRight", aRight, 5);
    checkOutput("preResetDir", aDir, 0);
    checkOutput("preResetState", aState, 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("midPlayResetState", aState, 0);
    checkOutput("midPlayResetLeft", aLeft, 0);
    checkOutput("midPlayResetRight", aRight, 0);
    checkOutput("midPlayResetHold", aHold, 1);
    checkOutput("midPlayResetDir", aDir, 1);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);

    applyStimulus(0, 1, 0, 0);
    serveTicks(1);
    repeat (9) scorePoint(0, 1);
    repeat (10) scorePoint(1, 0);
    checkOutput("noWin10to9", bOver, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("firstToWinLeft", bLeft, 11);
    applyStimulus(0, 0, 0, 0);
    checkOutput("firstToWinOver", bOver, 1);
    checkOutput("firstToWinWinner", bWinner, 0);
    checkOutput("firstToWinState", bState, 4);
    checkOutput("winByTwo11to9", aOver, 1);

    applyStimulus(0, 1, 0, 0);
    checkOutput("restartLeft", aLeft, 0);
    checkOutput("restartRight", aRight, 0);
    checkOutput("restartState", aState, 1);
    checkOutput("restartOver", aOver, 0);
    checkOutput("restartDir", aDir, 1);
    serveTicks(1);

    for (int i = 0; i < 10; i++) begin
      scorePoint(1, 0);
      scorePoint(0, 1);
    end
    checkOutput("tenAllState", aState, 2);
    applyStimulus(0, 0, 1, 0);
    checkOutput("elevenTenLeft", aLeft, 11);
    applyStimulus(0, 0, 0, 0);
    checkOutput("elevenTenNoOver", aOver, 0);
    checkOutput("elevenTenState", aState, 3);
    checkOutput("elevenTenFirstTo", bOver, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    serveTicks(1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("twelveTenLeft", aLeft, 12);
    checkOutput("overNotYet", aOver, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("twelveTenOver", aOver, 1);
    checkOutput("twelveTenWinner", aWinner, 0);
    checkOutput("twelveTenState", aState, 4);

    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(0, 1, 0, 0);
    serveTicks(1);
    repeat (2) scorePoint(0, 1);
    checkOutput("capBelowCap", cOver, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("capScore", cRight, 3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("capOver", cOver, 1);
    checkOutput("capWinner", cWinner, 1);
    checkOutput("capState", cState, 4);
    applyStimulus(0, 0, 0, 1);
    checkOutput("capStays", cRight, 3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
